// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle main FSM and the RV32I datapath/memory.
// The controller uses the master modport; the datapath side uses slave.
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic       retire;
    logic       bus_err;
    logic [3:0] state_o;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, imm_src,
               retire, bus_err, state_o
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, imm_src,
               retire, bus_err, state_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: fetch/decode/execute/mem/writeback
// sequencing, memory request handshake and a memory-wait watchdog.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcode traps instead of acting as a NOP).
module multicycle_ctrl #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXR    = 4'd6,  S_EXI    = 4'd7,
        S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_LUI    = 4'd11,
        S_AUIPC  = 4'd12, S_TRAP   = 4'd13, S_ERR    = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_waitCnt;
    logic [CNT_W-1:0] w_cntInc;
    logic             r_busErr;
    logic             w_memReq;
    logic             w_timeout;
    logic             w_illegal;

    assign w_memReq  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_cntInc  = r_waitCnt + 1'b1;
    assign w_timeout = (TIMEOUT_CYC != 0) && w_memReq && !bus.mem_ready
                       && (w_cntInc == CNT_W'(TIMEOUT_CYC));

    // Flag opcodes the core does not implement so DECODE can trap or skip them
    always_comb begin
        w_illegal = 1'b1;
        case (bus.opcode)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
            OP_BEQ, OP_JAL, OP_LUI, OP_AUIPC: w_illegal = 1'b0;
            default:                          w_illegal = 1'b1;
        endcase
    end

    // State register; reset always returns to FETCH
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_nextState;
    end

    // Count stalled memory cycles; any completion or state change restarts the count
    always_ff @(posedge clk) begin
        if (reset || !w_memReq || bus.mem_ready || (w_nextState != r_state))
            r_waitCnt <= '0;
        else
            r_waitCnt <= w_cntInc;
    end

    // Sticky bus error, set when the watchdog fires and cleared only by reset
    always_ff @(posedge clk) begin
        if (reset)          r_busErr <= 1'b0;
        else if (w_timeout) r_busErr <= 1'b1;
    end

    // Next-state logic: memory states wait for mem_ready unless the watchdog fires first
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_FETCH:  if (bus.mem_ready) w_nextState = S_DECODE;
                      else if (w_timeout) w_nextState = S_ERR;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: w_nextState = S_MEMADR;
                    OP_RTYPE:          w_nextState = S_EXR;
                    OP_ITYPE:          w_nextState = S_EXI;
                    OP_BEQ:            w_nextState = S_BRANCH;
                    OP_JAL:            w_nextState = S_JAL;
                    OP_LUI:            w_nextState = S_LUI;
                    OP_AUIPC:          w_nextState = S_AUIPC;
                    default:           w_nextState = S_FETCH;
                endcase
                if (w_illegal) begin
`ifdef ILLEGAL_TRAP_EN
                    w_nextState = S_TRAP;
`else
                    w_nextState = S_FETCH;
`endif
                end
            end
            S_MEMADR: w_nextState = (bus.opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.mem_ready) w_nextState = S_MEMWB;
                      else if (w_timeout) w_nextState = S_ERR;
            S_MEMWB:  w_nextState = S_FETCH;
            S_MEMWR:  if (bus.mem_ready) w_nextState = S_FETCH;
                      else if (w_timeout) w_nextState = S_ERR;
            S_EXR, S_EXI, S_JAL, S_LUI, S_AUIPC: w_nextState = S_ALUWB;
            S_ALUWB, S_BRANCH: w_nextState = S_FETCH;
            S_TRAP:   w_nextState = S_TRAP;
            S_ERR:    w_nextState = S_ERR;
            default:  w_nextState = S_FETCH;
        endcase
    end

    // Output decode: Moore controls from state, handshake-dependent strobes gated by mem_ready
    always_comb begin
        bus.mem_req    = w_memReq;
        bus.mem_we     = 1'b0;
        bus.adr_src    = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 2'd0;
        bus.alu_src_b  = 2'd0;
        bus.alu_op     = 2'd0;
        bus.result_src = 2'd0;
        bus.imm_src    = 3'd0;
        bus.retire     = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.alu_src_b = 2'd2;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_a = 2'd1;
                bus.alu_src_b = 2'd1;
                bus.imm_src   = 3'd2;
`ifndef ILLEGAL_TRAP_EN
                bus.retire    = w_illegal;
`endif
            end
            S_MEMADR: begin
                bus.alu_src_a = 2'd2;
                bus.alu_src_b = 2'd1;
                bus.imm_src   = (bus.opcode == OP_STORE) ? 3'd1 : 3'd0;
            end
            S_MEMRD:  bus.adr_src = 1'b1;
            S_MEMWB: begin
                bus.result_src = 2'd1;
                bus.reg_write  = 1'b1;
                bus.retire     = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_we  = 1'b1;
                bus.adr_src = 1'b1;
                bus.retire  = bus.mem_ready;
            end
            S_EXR: begin
                bus.alu_src_a = 2'd2;
                bus.alu_op    = 2'd2;
            end
            S_EXI: begin
                bus.alu_src_a = 2'd2;
                bus.alu_src_b = 2'd1;
                bus.alu_op    = 2'd2;
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
                bus.retire    = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = 2'd2;
                bus.alu_op    = 2'd1;
                bus.pc_write  = bus.zero;
                bus.retire    = 1'b1;
            end
            S_JAL: begin
                bus.alu_src_a = 2'd1;
                bus.alu_src_b = 2'd2;
                bus.imm_src   = 3'd3;
                bus.pc_write  = 1'b1;
            end
            S_LUI: begin
                bus.alu_src_a = 2'd3;
                bus.alu_src_b = 2'd1;
                bus.imm_src   = 3'd4;
            end
            S_AUIPC: begin
                bus.alu_src_a = 2'd1;
                bus.alu_src_b = 2'd1;
                bus.imm_src   = 3'd4;
            end
            default: ;
        endcase
        if (reset) begin
            bus.mem_we     = 1'b0;
            bus.adr_src    = 1'b0;
            bus.ir_write   = 1'b0;
            bus.pc_write   = 1'b0;
            bus.reg_write  = 1'b0;
            bus.alu_src_a  = 2'd0;
            bus.alu_src_b  = 2'd0;
            bus.alu_op     = 2'd0;
            bus.result_src = 2'd0;
            bus.imm_src    = 3'd0;
            bus.retire     = 1'b0;
        end
    end

    assign bus.bus_err = r_busErr;
    assign bus.state_o = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: random instruction stream with random
// memory latency compared against a per-instruction transaction model, plus directed
// watchdog, reset-mid-access and illegal-opcode scenarios.
module tb_multicycle_ctrl;

    localparam int TMO = 4;

    logic clk;
    logic reset;
    int   compCnt = 0;
    int   failCnt = 0;

    multicycle_ctrl_if busIf ();

    multicycle_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports any difference
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs one instruction from FETCH to retire; dF/dM are wait cycles for fetch and data access
    task automatic applyStimulus(input logic [6:0] opc, input logic z, input int dF, input int dM);
        int waitLeft = dF;
        int retCyc   = -1;
        int nRegW = 0, nPcW = 0, nIrW = 0, nReq = 0, nWe = 0;
        logic [2:0] decImm = 3'd7, s3Imm = 3'd7;
        bit isLoad, isStore, isR, isI, isBr, isJal, isU, isMem;
        int expCyc, expPc, expImm3;
        isLoad  = (opc == 7'b0000011);
        isStore = (opc == 7'b0100011);
        isR     = (opc == 7'b0110011);
        isI     = (opc == 7'b0010011);
        isBr    = (opc == 7'b1100011);
        isJal   = (opc == 7'b1101111);
        isU     = (opc == 7'b0110111) || (opc == 7'b0010111);
        isMem   = isLoad || isStore;

        busIf.opcode = opc;
        busIf.zero   = z;
        for (int cyc = 0; cyc < 40 && retCyc < 0; cyc++) begin
            #1;
            if (busIf.mem_req) begin
                if (waitLeft > 0) begin
                    busIf.mem_ready = 1'b0;
                    waitLeft--;
                end else begin
                    busIf.mem_ready = 1'b1;
                    waitLeft = dM;
                end
            end else begin
                busIf.mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            nRegW += int'(busIf.reg_write);
            nPcW  += int'(busIf.pc_write);
            nIrW  += int'(busIf.ir_write);
            nReq  += int'(busIf.mem_req);
            nWe   += int'(busIf.mem_we);
            if (cyc == dF + 1) decImm = busIf.imm_src;
            if (cyc == dF + 2) s3Imm  = busIf.imm_src;
            if (busIf.retire) retCyc = cyc;
            @(negedge clk);
        end

        // Transaction model: cycle cost and strobe counts from the instruction class
        expCyc = 2 + dF;
        if (isLoad)                           expCyc += 3 + dM;
        else if (isStore)                     expCyc += 2 + dM;
        else if (isR || isI || isU || isJal)  expCyc += 2;
        else if (isBr)                        expCyc += 1;
        expPc   = 1 + ((isBr && z) ? 1 : 0) + (isJal ? 1 : 0);
        expImm3 = isStore ? 1 : (isJal ? 3 : (isU ? 4 : 0));

        checkOutput($sformatf("cycles_op%02h", opc), retCyc + 1, expCyc);
        checkOutput("reg_write_cnt", nRegW, (isLoad || isR || isI || isU || isJal) ? 1 : 0);
        checkOutput("pc_write_cnt", nPcW, expPc);
        checkOutput("ir_write_cnt", nIrW, 1);
        checkOutput("mem_req_cnt", nReq, 1 + dF + (isMem ? 1 + dM : 0));
        checkOutput("mem_we_cnt", nWe, isStore ? 1 + dM : 0);
        checkOutput("decode_imm_src", 32'(decImm), 2);
        if (isLoad || isStore || isI || isJal || isU)
            checkOutput("stage3_imm_src", 32'(s3Imm), expImm3);
        #1;
        checkOutput("back_to_fetch", 32'(busIf.state_o), 0);
    endtask

    logic [6:0] opTab [9];
    bit         found;

    initial begin
        opTab[0] = 7'b0000011; opTab[1] = 7'b0100011; opTab[2] = 7'b0110011;
        opTab[3] = 7'b0010011; opTab[4] = 7'b1100011; opTab[5] = 7'b1101111;
        opTab[6] = 7'b0110111; opTab[7] = 7'b0010111; opTab[8] = 7'b1111111;

        reset           = 1'b1;
        busIf.opcode    = 7'b0000011;
        busIf.zero      = 1'b0;
        busIf.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_state", 32'(busIf.state_o), 0);
        checkOutput("rst_bus_err", 32'(busIf.bus_err), 0);
        checkOutput("rst_reg_write", 32'(busIf.reg_write), 0);
        checkOutput("rst_pc_write", 32'(busIf.pc_write), 0);
        checkOutput("rst_retire", 32'(busIf.retire), 0);
        checkOutput("rst_alu_src_b", 32'(busIf.alu_src_b), 0);
        reset = 1'b0;

        // Watchdog: fetch never answered, ERR after exactly TMO waiting cycles
        for (int i = 0; i < TMO; i++) begin
            checkOutput($sformatf("wd_wait%0d", i), 32'(busIf.state_o), 0);
            @(negedge clk);
            #1;
        end
        checkOutput("wd_err_state", 32'(busIf.state_o), 14);
        for (int i = 0; i < 3; i++) begin
            busIf.mem_ready = 1'($urandom_range(0, 1));
            #1;
            checkOutput("wd_bus_err_sticky", 32'(busIf.bus_err), 1);
            checkOutput("wd_err_no_req", 32'(busIf.mem_req), 0);
            checkOutput("wd_err_no_retire", 32'(busIf.retire), 0);
            @(negedge clk);
            #1;
        end
        checkOutput("wd_err_held", 32'(busIf.state_o), 14);
        reset = 1'b1;
        busIf.mem_ready = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("wd_rst_bus_err", 32'(busIf.bus_err), 0);
        checkOutput("wd_rst_state", 32'(busIf.state_o), 0);
        reset = 1'b0;

        // Directed: lw no wait, sw with 3-cycle data wait, beq taken/not taken, limit-edge fetch
        applyStimulus(7'b0000011, 1'b0, 0, 0);
        applyStimulus(7'b0100011, 1'b0, 0, 3);
        applyStimulus(7'b1100011, 1'b1, 0, 0);
        applyStimulus(7'b1100011, 1'b0, 0, 0);
        applyStimulus(7'b0000011, 1'b0, TMO - 1, TMO - 1);

        // Random instruction stream with random memory latency below the watchdog limit
        for (int n = 0; n < 30; n++) begin
            int k;
`ifdef ILLEGAL_TRAP_EN
            k = $urandom_range(0, 7);
`else
            k = $urandom_range(0, 8);
`endif
            applyStimulus(opTab[k], 1'($urandom_range(0, 1)),
                          $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1));
        end

        // Reset while a load waits in MEMRD
        busIf.opcode = 7'b0000011;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            busIf.mem_ready = 1'b1;
            #1;
            if (busIf.state_o == 4'd3) found = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        checkOutput("reach_memrd", 32'(found), 1);
        busIf.mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("rstmid_reg_write", 32'(busIf.reg_write), 0);
        checkOutput("rstmid_retire", 32'(busIf.retire), 0);
        @(negedge clk);
        #1;
        checkOutput("rstmid_state", 32'(busIf.state_o), 0);
        checkOutput("rstmid_bus_err", 32'(busIf.bus_err), 0);
        checkOutput("rstmid_post_reg_write", 32'(busIf.reg_write), 0);
        checkOutput("rstmid_post_retire", 32'(busIf.retire), 0);
        reset = 1'b0;

`ifdef ILLEGAL_TRAP_EN
        // Illegal opcode traps and stays in TRAP with no retire
        busIf.opcode    = 7'b1111111;
        busIf.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("trap_state", 32'(busIf.state_o), 13);
            checkOutput("trap_retire", 32'(busIf.retire), 0);
            checkOutput("trap_no_req", 32'(busIf.mem_req), 0);
            @(negedge clk);
        end
`else
        // Illegal opcode behaves as a NOP: FETCH, DECODE with retire, back to FETCH
        applyStimulus(7'b1111111, 1'b0, 1, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, failCnt);
        $finish;
    end

endmodule
